// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads win, then the clear sweep, then buffered game writes.
// Reads return one cycle later and are forwarded from the write buffer so scanout never sees stale cells.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  logic                r_clr_busy;
  logic                r_clr_pend;
  logic [ADDR_W-1:0]   r_clr_cnt;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                r_scan_valid;
  logic                r_fwd_hit;
  logic [DATA_W-1:0]   r_fwd_data;
  logic                r_ovf;

  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_enq;
  logic                w_deq;
  logic                w_clr_step;
  logic                w_fwd_hit;
  logic [DATA_W-1:0]   w_fwd_data;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] rd, input int age);
    int s;
    s = (int'(rd) + age) % FIFO_DEPTH;
    return PTR_W'(s);
  endfunction

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == DEPTH_C);
  assign wr_ready     = !w_fifo_full && !r_clr_busy;
  assign w_enq        = wr_req && wr_ready;
  assign w_clr_step   = (r_state == S_CLEAR) && !scan_req;
  // Buffered writes only reach RAM outside a clear; the FIFO is always empty during one anyway.
  assign w_deq        = !w_fifo_empty && !scan_req && (r_state == S_IDLE);

  assign clr_busy   = r_clr_busy;
  assign ovf        = r_ovf;
  assign scan_valid = r_scan_valid;
  assign scan_data  = r_scan_valid ? (r_fwd_hit ? r_fwd_data : mem_rdata) : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (scan_req) begin
      mem_en   = 1'b1;
      mem_addr = scan_addr;
    end else if (w_clr_step) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = r_clr_cnt;
    end else if (w_deq) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_fifo_addr[r_rd_ptr];
      mem_wdata = r_fifo_data[r_rd_ptr];
    end
  end

  // Walk oldest to newest so the last match left standing is the newest one.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_fifo_addr[slot_of(r_rd_ptr, i)] == scan_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_fifo_data[slot_of(r_rd_ptr, i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_deq) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_valid <= 1'b0;
      r_fwd_hit    <= 1'b0;
      r_fwd_data   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_scan_valid <= scan_req;
      r_fwd_hit    <= scan_req && w_fwd_hit;
      r_fwd_data   <= w_fwd_data;
      if (wr_req && !wr_ready) r_ovf <= 1'b1;
    end
  end

  // A clear starts only once nothing is buffered, so it cannot overwrite a newer game write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_clr_busy <= 1'b0;
      r_clr_pend <= 1'b0;
      r_clr_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((clr_req || r_clr_pend) && w_fifo_empty && !w_enq) begin
            r_state    <= S_CLEAR;
            r_clr_busy <= 1'b1;
            r_clr_pend <= 1'b0;
            r_clr_cnt  <= '0;
          end else if (clr_req) begin
            r_clr_pend <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_clr_step) begin
            if (r_clr_cnt == LAST_ADDR) begin
              r_state    <= S_IDLE;
              r_clr_busy <= 1'b0;
              r_clr_cnt  <= '0;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a RAM model and a scanout-data scoreboard.
module tb_vga_fb_arbiter;
  localparam int AW = 4;
  localparam int DW = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clr_req;
  logic          clr_busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          ovf;

  logic [DW-1:0] ram    [16];
  logic [DW-1:0] shadow [16];
  logic          ram_loaded = 1'b0;
  logic [DW-1:0] sb [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ovf(ovf)
  );

`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

  // Single-port RAM with one-cycle read latency, preloaded with cell value (addr+1).
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) ram[i] <= DW'(i + 1);
      ram_loaded <= 1'b1;
    end else if (mem_en === 1'b1) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst === 1'b1 && scan_valid === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL scan_unexpected observed=%0h expected=no_pending_scan", scan_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        `CHK("scan_data", scan_data, e)
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    scan_req = 1'b0;
    wr_req   = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic do_scan(input logic [AW-1:0] a);
    scan_req  = 1'b1;
    scan_addr = a;
    sb.push_back(shadow[a]);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (accept) shadow[a] = d;
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    idle_in();
    scan_addr = '0;
    wr_addr   = '0;
    wr_data   = '0;
    for (int i = 0; i < 16; i++) shadow[i] = DW'(i + 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    `CHK("rst_scan_valid", scan_valid, 1'b0)
    `CHK("rst_scan_data", scan_data, 3'd0)
    `CHK("rst_ovf", ovf, 1'b0)
    `CHK("rst_clr_busy", clr_busy, 1'b0)
    `CHK("rst_wr_ready", wr_ready, 1'b1)
    `CHK("rst_mem_en", mem_en, 1'b0)
    @(posedge clk);
    #1 rst = 1'b1;

    // Single write with scanout idle
    do_write(4'd5, 3'd3, 1'b1);
    @(negedge clk);
    `CHK("t31_ready", wr_ready, 1'b1)
    `CHK("t31_no_we_yet", mem_we, 1'b0)
    tick();
    idle_in();
    @(negedge clk);
    `CHK("t31_en", mem_en, 1'b1)
    `CHK("t31_we", mem_we, 1'b1)
    `CHK("t31_addr", mem_addr, 4'd5)
    `CHK("t31_wdata", mem_wdata, 3'd3)
    tick();
    @(negedge clk);
    `CHK("t31_empty_en", mem_en, 1'b0)
    `CHK("t31_empty_ready", wr_ready, 1'b1)
    tick();

    // Continuous scan with five writes: fifth overflows
    for (int c = 0; c < 10; c++) begin
      do_scan(AW'(c));
      if (c < 5) do_write(AW'(10 + c), DW'(c + 2), c < 4);
      else wr_req = 1'b0;
      @(negedge clk);
      `CHK("t32_scan_en", mem_en, 1'b1)
      `CHK("t32_no_we", mem_we, 1'b0)
      `CHK("t32_scan_addr", mem_addr, AW'(c))
      if (c < 4) `CHK("t32_ready_hi", wr_ready, 1'b1)
      else       `CHK("t32_ready_lo", wr_ready, 1'b0)
      if (c > 0) `CHK("t32_scan_valid", scan_valid, 1'b1)
      if (c >= 5) `CHK("t32_ovf", ovf, 1'b1)
      tick();
    end
    idle_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) `CHK("t32_last_valid", scan_valid, 1'b1)
      `CHK("t32_drain_we", mem_we, 1'b1)
      `CHK("t32_drain_addr", mem_addr, AW'(10 + k))
      `CHK("t32_drain_data", mem_wdata, DW'(k + 2))
      tick();
    end
    @(negedge clk);
    `CHK("t32_idle_en", mem_en, 1'b0)
    `CHK("t32_idle_ready", wr_ready, 1'b1)
    `CHK("t32_idle_valid", scan_valid, 1'b0)
    tick();

    // Read-after-write forwarding, newest entry wins
    do_scan(4'd0);
    do_write(4'd9, 3'd6, 1'b1);
    @(negedge clk);
    `CHK("t33_no_we0", mem_we, 1'b0)
    tick();
    do_scan(4'd9);
    do_write(4'd9, 3'd1, 1'b1);
    @(negedge clk);
    `CHK("t33_no_we1", mem_we, 1'b0)
    `CHK("t33_ready", wr_ready, 1'b1)
    tick();
    do_scan(4'd9);
    wr_req = 1'b0;
    @(negedge clk);
    `CHK("t33_no_we2", mem_we, 1'b0)
    tick();
    idle_in();
    @(negedge clk);
    `CHK("t33_valid", scan_valid, 1'b1)
    `CHK("t33_drain1_addr", mem_addr, 4'd9)
    `CHK("t33_drain1_data", mem_wdata, 3'd6)
    `CHK("t33_drain1_we", mem_we, 1'b1)
    tick();
    @(negedge clk);
    `CHK("t33_drain2_data", mem_wdata, 3'd1)
    `CHK("t33_drain2_we", mem_we, 1'b1)
    tick();
    do_scan(4'd9);
    @(negedge clk);
    `CHK("t33_ram_read", mem_we, 1'b0)
    tick();
    idle_in();
    @(negedge clk);
    `CHK("t33_valid2", scan_valid, 1'b1)
    tick();

    // Full clear sweep with no scan; second clr_req mid-sweep ignored
    clr_req = 1'b1;
    @(negedge clk);
    `CHK("t34_busy_pre", clr_busy, 1'b0)
    `CHK("t34_en_pre", mem_en, 1'b0)
    tick();
    for (int k = 0; k < 16; k++) begin
      clr_req = (k == 4);
      @(negedge clk);
      `CHK("t34_busy", clr_busy, 1'b1)
      `CHK("t34_ready", wr_ready, 1'b0)
      `CHK("t34_we", mem_we, 1'b1)
      `CHK("t34_addr", mem_addr, AW'(k))
      `CHK("t34_wdata", mem_wdata, 3'd0)
      tick();
    end
    clr_req = 1'b0;
    @(negedge clk);
    `CHK("t34_busy_post", clr_busy, 1'b0)
    `CHK("t34_en_post", mem_en, 1'b0)
    `CHK("t34_ready_post", wr_ready, 1'b1)
    tick();
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Clear requested with two buffered writes
    do_scan(4'd1);
    do_write(4'd2, 3'd5, 1'b1);
    @(negedge clk);
    `CHK("t35_no_we0", mem_we, 1'b0)
    tick();
    do_scan(4'd2);
    do_write(4'd3, 3'd7, 1'b1);
    @(negedge clk);
    `CHK("t35_no_we1", mem_we, 1'b0)
    tick();
    idle_in();
    clr_req = 1'b1;
    @(negedge clk);
    `CHK("t35_drain1_addr", mem_addr, 4'd2)
    `CHK("t35_drain1_data", mem_wdata, 3'd5)
    `CHK("t35_pend_busy", clr_busy, 1'b0)
    tick();
    clr_req = 1'b0;
    @(negedge clk);
    `CHK("t35_drain2_addr", mem_addr, 4'd3)
    `CHK("t35_drain2_we", mem_we, 1'b1)
    `CHK("t35_pend_busy2", clr_busy, 1'b0)
    tick();
    @(negedge clk);
    `CHK("t35_gap_en", mem_en, 1'b0)
    tick();
    cnt = 0;
    for (int s = 0; s < 17; s++) begin
      if (s == 3) do_scan(4'd3);
      else scan_req = 1'b0;
      @(negedge clk);
      `CHK("t35_busy", clr_busy, 1'b1)
      if (s == 3) begin
        `CHK("t35_stall_we", mem_we, 1'b0)
        `CHK("t35_stall_addr", mem_addr, 4'd3)
      end else begin
        `CHK("t35_clr_we", mem_we, 1'b1)
        `CHK("t35_clr_addr", mem_addr, AW'(cnt))
        cnt++;
      end
      tick();
    end
    idle_in();
    @(negedge clk);
    `CHK("t35_busy_post", clr_busy, 1'b0)
    `CHK("t35_en_post", mem_en, 1'b0)
    tick();
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Reset in the middle of a clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    #1;
    `CHK("t36_cnt7_addr", mem_addr, 4'd7)
    `CHK("t36_cnt7_we", mem_we, 1'b1)
    rst = 1'b0;
    #1;
    `CHK("t36_rst_en", mem_en, 1'b0)
    `CHK("t36_rst_we", mem_we, 1'b0)
    `CHK("t36_rst_busy", clr_busy, 1'b0)
    `CHK("t36_rst_ovf", ovf, 1'b0)
    `CHK("t36_rst_valid", scan_valid, 1'b0)
    `CHK("t36_rst_data", scan_data, 3'd0)
    `CHK("t36_rst_ready", wr_ready, 1'b1)
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      `CHK("t36_post_en", mem_en, 1'b0)
      `CHK("t36_post_busy", clr_busy, 1'b0)
      tick();
    end

    @(negedge clk);
    `CHK("sb_empty", sb.size(), 0)
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
